// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, radix constants and FSM state encoding.
// Used by bcd_digit_sub and bcd_serial_subtractor.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX   = 4'd9;
  localparam bcd_digit_t BCD_RADIX = 4'd10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor (combinational): d_i = a_i - b_i - bin.
// Ports:
//   a_i, b_i  in   minuend / subtrahend digit
//   bin       in   borrow-in
//   d_i       out  difference digit (ten's-complement corrected on borrow)
//   bout      out  borrow-out
//   invalid   out  either input digit exceeds 9
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       bin,
  output bcd_digit_t d_i,
  output logic       bout,
  output logic       invalid
);

  logic [DIGIT_W:0] t;

  // Binary difference; a negative result is pulled back into 0..9 by adding the radix.
  always_comb begin
    t       = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT_W{1'b0}}, bin};
    bout    = t[DIGIT_W];
    d_i     = t[DIGIT_W] ? bcd_digit_t'(t[DIGIT_W-1:0] + BCD_RADIX) : t[DIGIT_W-1:0];
    invalid = (a_i > BCD_MAX) || (b_i > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial multi-digit BCD subtractor: d = a - b - bin, one digit per clock, LSD first.
// Optional macro BCD_SUB_DIGIT_CHECK_EN enables invalid-digit flagging on err.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   start      request, accepted when busy==0 (IDLE or DONE)
//   a, b, bin  packed BCD minuend, subtrahend, borrow-in to digit 0
//   busy       digits being processed
//   done       one-cycle pulse, d/bout/err valid
//   d          difference (ten's complement when bout=1)
//   bout       borrow-out of the most significant digit
//   err        invalid-digit flag (0 unless BCD_SUB_DIGIT_CHECK_EN)
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic                  bout,
  output logic                  err
);

  localparam int unsigned W  = DIGIT_W * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_SUB_DIGIT_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [IW-1:0] idx;
  logic          borrow;
  logic          accept_c;
  logic          last_c;
  bcd_digit_t    d_i;
  logic          bout_i;
  logic          invalid_i;

  // Current digit always sits in the low nibble of the shifted operands.
  bcd_digit_sub u_digit (
    .a_i     (a_sh[DIGIT_W-1:0]),
    .b_i     (b_sh[DIGIT_W-1:0]),
    .bin     (borrow),
    .d_i     (d_i),
    .bout    (bout_i),
    .invalid (invalid_i)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    accept_c  = start && (state != ST_RUN);
    last_c    = (state == ST_RUN) && (idx == IW'(DIGITS - 1));
    case (state)
      ST_IDLE: if (accept_c) state_nxt = ST_RUN;
      ST_RUN:  if (last_c)   state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept_c ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        a_sh   <= a;
        b_sh   <= b;
        borrow <= bin;
        idx    <= '0;
        busy   <= 1'b1;
        d      <= '0;
        err    <= 1'b0;
      end else if (state == ST_RUN) begin
        d[{idx, 2'b00} +: DIGIT_W] <= d_i;
        a_sh   <= a_sh >> DIGIT_W;
        b_sh   <= b_sh >> DIGIT_W;
        borrow <= bout_i;
        idx    <= idx + 1'b1;
        err    <= err | (CHECK_EN & invalid_i);
        if (last_c) begin
          bout <= bout_i;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
